// File: rtl/raster_pkg.sv
// Shared types and constants for the triangle dispatch path in front of the rasterizer.
package raster_pkg;

    localparam int TRI_W    = 360;
    localparam int FB_W     = 26;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Screen-space triangle, MSB first: nine 32-bit coordinates then three 24-bit RGB colours.
    typedef struct packed {
        logic [31:0] x1;
        logic [31:0] y1;
        logic [31:0] z1;
        logic [31:0] x2;
        logic [31:0] y2;
        logic [31:0] z2;
        logic [31:0] x3;
        logic [31:0] y3;
        logic [31:0] z3;
        logic [23:0] color1;
        logic [23:0] color2;
        logic [23:0] color3;
    } triangle_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT      = 2'd2,
        ST_FLIP_WAIT = 2'd3
    } dispatch_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/raster_dispatch_tri_fifo.sv
// Synchronous FIFO with registered occupancy count; head is read combinationally from storage.
module tri_fifo #(
    parameter int WIDTH = 361,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign data_o    = mem_q[rd_ptr_q];

    // Storage write; contents need no reset because the count gates every read.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW+1)'(1'b1);
                2'b01:   count_q <= count_q - (AW+1)'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/raster_dispatch.sv
// Triangle dispatch controller: queues triangles, issues one at a time to the rasterizer,
// and flips the double-buffered frame buffer once a frame's last triangle completes.
module raster_dispatch
    import raster_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [FB_W-1:0] FB_BASE0 = 26'h000_0000,
    parameter logic [FB_W-1:0] FB_BASE1 = 26'h004_B000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tri_in_valid,
    output logic              tri_in_ready,
    input  logic [TRI_W-1:0]  tri_in_data,
    input  logic              tri_in_last,
    output logic              rast_valid,
    input  logic              rast_ready,
    output logic [TRI_W-1:0]  rast_data,
    output logic [FB_W-1:0]   rast_addr,
    input  logic              rast_done,
    input  logic              swap_req,
    output logic [FB_W-1:0]   front_base,
    output logic              frame_done,
    output logic [15:0]       tri_count
);

    dispatch_state_t  state_q, state_d;
    logic             last_q, last_d;
    logic             rast_valid_q, rast_valid_d;
    logic [TRI_W-1:0] rast_data_q, rast_data_d;
    logic [FB_W-1:0]  back_q, back_d;
    logic [FB_W-1:0]  front_q, front_d;
    logic             frame_done_q, frame_done_d;
    logic [15:0]      tri_count_q, tri_count_d;

    logic             fifo_pop_s;
    logic [TRI_W:0]   fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;

    tri_fifo #(
        .WIDTH (TRI_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (tri_in_valid),
        .data_i  ({tri_in_data, tri_in_last}),
        .pop_i   (fifo_pop_s),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign tri_in_ready = !fifo_full_s;
    assign rast_valid   = rast_valid_q;
    assign rast_data    = rast_data_q;
    assign rast_addr    = back_q;
    assign front_base   = front_q;
    assign frame_done   = frame_done_q;
    assign tri_count    = tri_count_q;

    // Next-state and output-register logic for the dispatch FSM.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        rast_valid_d = rast_valid_q;
        rast_data_d  = rast_data_q;
        back_d       = back_q;
        front_d      = front_q;
        frame_done_d = 1'b0;
        tri_count_d  = tri_count_q;
        fifo_pop_s   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // First ISSUE cycle loads the output registers; the head cannot move until we pop.
                if (!rast_valid_q) begin
                    rast_valid_d = 1'b1;
                    rast_data_d  = fifo_head_s[TRI_W:1];
                end else if (rast_ready) begin
                    rast_valid_d = 1'b0;
                    fifo_pop_s   = 1'b1;
                    last_d       = fifo_head_s[0];
                    state_d      = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (rast_done) begin
                    tri_count_d = sat_inc16(tri_count_q);
                    if (last_q) begin
                        state_d = ST_FLIP_WAIT;
                    end else if (!fifo_empty_s) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_FLIP_WAIT: begin
                if (swap_req) begin
                    back_d       = front_q;
                    front_d      = back_q;
                    frame_done_d = 1'b1;
                    tri_count_d  = 16'd0;
                    last_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_FLIP_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight triangle without flipping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b0;
            rast_valid_q <= 1'b0;
            rast_data_q  <= '0;
            back_q       <= FB_BASE0;
            front_q      <= FB_BASE1;
            frame_done_q <= 1'b0;
            tri_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            rast_valid_q <= rast_valid_d;
            rast_data_q  <= rast_data_d;
            back_q       <= back_d;
            front_q      <= front_d;
            frame_done_q <= frame_done_d;
            tri_count_q  <= tri_count_d;
        end
    end

endmodule

// File: tb/tb_raster_dispatch.sv
// Scoreboard bench for raster_dispatch: pushes record expected issues, a negedge monitor checks them.
module tb_raster_dispatch;
    import raster_pkg::*;

    localparam logic [25:0] FB0 = 26'h000_0000;
    localparam logic [25:0] FB1 = 26'h004_B000;

    logic         clock;
    logic         reset;
    logic         tri_in_valid;
    logic         tri_in_ready;
    logic [359:0] tri_in_data;
    logic         tri_in_last;
    logic         rast_valid;
    logic         rast_ready;
    logic [359:0] rast_data;
    logic [25:0]  rast_addr;
    logic         rast_done;
    logic         swap_req;
    logic [25:0]  front_base;
    logic         frame_done;
    logic [15:0]  tri_count;

    typedef struct packed {
        logic [359:0] data;
        logic [25:0]  addr;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    int     frames_pushed = 0;
    bit     auto_done = 1'b0;
    int     done_delay = 5;
    int     done_cnt = 0;
    logic   done_auto = 1'b0;
    logic   done_man = 1'b0;

    assign rast_done = done_auto | done_man;

    raster_dispatch #(.DEPTH(4), .FB_BASE0(FB0), .FB_BASE1(FB1)) dut (
        .clock        (clock),
        .reset        (reset),
        .tri_in_valid (tri_in_valid),
        .tri_in_ready (tri_in_ready),
        .tri_in_data  (tri_in_data),
        .tri_in_last  (tri_in_last),
        .rast_valid   (rast_valid),
        .rast_ready   (rast_ready),
        .rast_data    (rast_data),
        .rast_addr    (rast_addr),
        .rast_done    (rast_done),
        .swap_req     (swap_req),
        .front_base   (front_base),
        .frame_done   (frame_done),
        .tri_count    (tri_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [359:0] gen(input int k);
        logic [359:0] v;
        v = '0;
        for (int b = 0; b < 45; b++) begin
            v[b*8 +: 8] = 8'((k * 37 + b * 5 + 1) & 255);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [359:0] act, input logic [359:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Monitor: scoreboard compare on every acceptance plus the rasterizer's done responder.
    always @(negedge clock) begin
        done_auto = 1'b0;
        if (!reset) begin
            exp_q.delete();
            done_cnt = 0;
        end else begin
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) done_auto = 1'b1;
            end
            if (rast_valid && rast_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got %0h expected no issue", rast_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("issue_data", rast_data, mon_e.data);
                    chk("issue_addr", {334'd0, rast_addr}, {334'd0, mon_e.addr});
                end
                if (auto_done) done_cnt = done_delay;
            end
        end
    end

    task automatic push(input int k, input logic last);
        bit   acc;
        int   n;
        exp_t e;
        tri_in_valid = 1'b1;
        tri_in_data  = gen(k);
        tri_in_last  = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = tri_in_ready;
            @(posedge clock);
            #1;
            n++;
        end
        tri_in_valid = 1'b0;
        if (acc) begin
            e.data = gen(k);
            e.addr = (frames_pushed % 2 == 1) ? FB1 : FB0;
            exp_q.push_back(e);
            if (last) frames_pushed++;
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout k=%0d: got no accept expected accept", k);
        end
    endtask

    task automatic wait_tc(input logic [15:0] v, input string name);
        int n;
        n = 0;
        while (tri_count !== v && n < 300) begin
            tick(1);
            n++;
        end
        chk(name, tri_count, v);
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        tri_in_valid = 1'b0;
        rast_ready   = 1'b0;
        swap_req     = 1'b0;
        auto_done    = 1'b0;
        done_man     = 1'b0;
        frames_pushed = 0;
        tick(2);
        chk("rst_in_ready", tri_in_ready, 1'b1);
        chk("rst_rast_valid", rast_valid, 1'b0);
        chk("rst_rast_data", rast_data, '0);
        chk("rst_rast_addr", rast_addr, FB0);
        chk("rst_front_base", front_base, FB1);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_tri_count", tri_count, 16'd0);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [359:0] cap_d;
        logic [25:0]  cap_a;
        bit           stable;
        int           vcount;

        reset = 1'b0; tri_in_valid = 1'b0; tri_in_data = '0; tri_in_last = 1'b0;
        rast_ready = 1'b0; swap_req = 1'b0;
        do_reset();

        // Reset mid-WAIT with three queued triangles, then first-issue latency.
        rast_ready = 1'b1;
        for (int k = 1; k <= 4; k++) push(k, 1'b0);
        tick(3);
        chk("midwait_valid", rast_valid, 1'b0);
        chk("midwait_ready", tri_in_ready, 1'b1);
        do_reset();
        rast_ready = 1'b1; auto_done = 1'b1; done_delay = 5;
        push(5, 1'b0);
        tick(1);
        chk("lat_n1_valid", rast_valid, 1'b0);
        tick(1);
        chk("lat_n2_valid", rast_valid, 1'b1);
        chk("lat_addr", rast_addr, FB0);
        wait_tc(16'd1, "lat_count");

        // Single two-triangle frame and flip.
        do_reset();
        rast_ready = 1'b1; auto_done = 1'b1; done_delay = 5;
        push(10, 1'b0);
        push(11, 1'b1);
        wait_tc(16'd2, "frame_count");
        tick(3);
        chk("flip_hold_count", tri_count, 16'd2);
        chk("flip_hold_front", front_base, FB1);
        chk("flip_hold_fdone", frame_done, 1'b0);
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        chk("flip_fdone", frame_done, 1'b1);
        chk("flip_front", front_base, FB0);
        chk("flip_addr", rast_addr, FB1);
        chk("flip_count", tri_count, 16'd0);
        tick(1);
        chk("flip_fdone_pulse", frame_done, 1'b0);

        // Backpressure: FIFO fills, outputs hold, fifth waits for a pop.
        rast_ready = 1'b0;
        for (int k = 20; k <= 23; k++) push(k, 1'b0);
        chk("bp_full", tri_in_ready, 1'b0);
        chk("bp_valid", rast_valid, 1'b1);
        cap_d = rast_data;
        cap_a = rast_addr;
        tri_in_valid = 1'b1; tri_in_data = gen(24); tri_in_last = 1'b0;
        stable = 1'b1;
        repeat (10) begin
            tick(1);
            if (rast_data !== cap_d || rast_addr !== cap_a || tri_in_ready !== 1'b0 || rast_valid !== 1'b1)
                stable = 1'b0;
        end
        tri_in_valid = 1'b0;
        chk("bp_stable", stable, 1'b1);
        chk("bp_data", cap_d, gen(20));
        chk("bp_addr", cap_a, FB1);
        rast_ready = 1'b1;
        push(24, 1'b0);
        wait_tc(16'd5, "bp_count");

        // Flip blocking: next frame waits in the FIFO until swap_req.
        push(30, 1'b1);
        wait_tc(16'd6, "fb_count");
        push(31, 1'b0);
        push(32, 1'b0);
        vcount = 0;
        repeat (20) begin
            tick(1);
            if (rast_valid) vcount++;
        end
        chk("fb_no_issue", vcount, 0);
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
        chk("fb_fdone", frame_done, 1'b1);
        chk("fb_front", front_base, FB1);
        tick(1);
        chk("fb_n1_valid", rast_valid, 1'b0);
        tick(1);
        chk("fb_n2_valid", rast_valid, 1'b1);
        chk("fb_addr", rast_addr, FB0);
        wait_tc(16'd2, "fb_drain");

        // Spurious done in IDLE and ISSUE is ignored.
        auto_done = 1'b0;
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
        tick(1);
        chk("spur_idle_count", tri_count, 16'd2);
        chk("spur_idle_valid", rast_valid, 1'b0);
        rast_ready = 1'b0;
        push(40, 1'b0);
        tick(2);
        chk("spur_issue_valid", rast_valid, 1'b1);
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
        tick(1);
        chk("spur_issue_count", tri_count, 16'd2);
        chk("spur_issue_hold", rast_valid, 1'b1);
        chk("spur_issue_data", rast_data, gen(40));
        auto_done = 1'b1;
        rast_ready = 1'b1;
        wait_tc(16'd3, "spur_after_count");

        // Wrap-around: ten triangles streamed through a four-entry FIFO.
        do_reset();
        rast_ready = 1'b1; auto_done = 1'b1; done_delay = 1;
        for (int k = 50; k < 60; k++) push(k, 1'b0);
        wait_tc(16'd10, "wrap_count");
        tick(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raster_dispatch.md
# raster_dispatch

Triangle dispatch controller in front of the rasterizer. It buffers incoming screen-space triangles in a small FIFO and issues them one at a time to the rasterizer, waiting for each to finish before issuing the next. It owns double-buffered frame-buffer selection: it supplies the back-buffer base address with every triangle and flips buffers on the display's swap request after a frame's last triangle completes.

## Interface
Parameters:
- DEPTH, 4: triangle FIFO entries; power of 2, minimum 2.
- FB_BASE0, 26'h000_0000: frame-buffer 0 base address.
- FB_BASE1, 26'h004_B000: frame-buffer 1 base address (640×480 past FB_BASE0).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, asynchronous, active-low; clock is clock.
- tri_in_valid  in  1  upstream triangle present.
- tri_in_ready  out  1  FIFO can accept; equals !full.
- tri_in_data  in  360  packed {x1,y1,z1,x2,y2,z2,x3,y3,z3 (32b each), color1,color2,color3 (24b RGB each)}, MSB first.
- tri_in_last  in  1  triangle is last of the frame; sampled with tri_in_data.
- rast_valid  out  1  triangle presented to rasterizer.
- rast_ready  in  1  rasterizer idle and accepting.
- rast_data  out  360  head triangle, same packing.
- rast_addr  out  26  back-buffer base for this triangle.
- rast_done  in  1  one-cycle pulse: current triangle fully rasterized.
- swap_req  in  1  display permits flip (vblank level).
- front_base  out  26  scanout buffer base.
- frame_done  out  1  one-cycle pulse on flip.
- tri_count  out  16  triangles completed in the current frame.

## Operation
- Push on tri_in_valid && tri_in_ready. Store {data,last}. No bypass: an empty FIFO is never read in the push cycle.
- FSM states: IDLE, ISSUE, WAIT, FLIP_WAIT.
  - IDLE: FIFO non-empty -> ISSUE.
  - ISSUE: rast_valid=1 with FIFO head. On rast_ready: pop, latch head's last flag into last_q -> WAIT.
  - WAIT: ignore everything except rast_done. On rast_done: tri_count++ (saturating at 16'hFFFF). Then last_q -> FLIP_WAIT; else non-empty -> ISSUE; else IDLE.
  - FLIP_WAIT: on swap_req: swap back/front bases, pulse frame_done, clear tri_count -> IDLE.
- FIFO keeps accepting during WAIT and FLIP_WAIT, including the next frame's triangles. Those triangles are not issued until the flip completes.
- rast_done outside WAIT is ignored and does not count.
- A frame with no last flag never flips.
- Simultaneous push and pop when full cannot occur (ready is low). Simultaneous push and pop otherwise leaves the count unchanged.
- Width rules: the pointers are log2(DEPTH) bits and wrap. The count is log2(DEPTH)+1 bits.

## Timing
- Reset state: state IDLE, FIFO empty, tri_in_ready=1, rast_valid=0, rast_data=0, rast_addr=FB_BASE0, front_base=FB_BASE1, frame_done=0, tri_count=0, last_q=0.
- Reset asserted mid-operation discards FIFO contents and the in-flight triangle. There is no partial flip.
- Latency: a triangle pushed into an empty FIFO at edge N with FSM in IDLE gives rast_valid high after edge N+2.
- rast_valid, rast_data and rast_addr are registered. They stay stable while rast_valid && !rast_ready.
- rast_valid drops the edge after acceptance.
- Back-to-back triangles: rast_done at edge M gives the next rast_valid after edge M+1.
- swap_req already high on entry to FLIP_WAIT flips at the next edge. frame_done is high for exactly one cycle.
- New front_base and rast_addr are visible after the same edge that pulses frame_done.

## Structure
- Package raster_pkg:
  - triangle_t packed struct matching the 360-bit layout.
  - TRI_W=360.
  - FB_W=26.
  - SCREEN_W=640, SCREEN_H=480.
  - dispatch_state_t enum.
- Sub-module tri_fifo (parameterised width/depth, synchronous, registered count, full/empty). The FSM, buffer selection and counter live in raster_dispatch.

## Test plan
- Reset: assert reset mid-WAIT with 3 queued triangles -> all outputs at reset values; first triangle pushed after release reaches rast_valid 2 edges later with rast_addr=26'h0000000.
- Single frame: push 2 triangles, second with last=1; rast_ready=1; rast_done 5 cycles after each acceptance; swap_req high -> tri_count=2 before flip; frame_done pulse; front_base=26'h0000000; rast_addr=26'h004B000; tri_count=0.
- Backpressure: hold rast_ready=0 for 10 cycles -> rast_data/rast_addr constant, no pop; FIFO fills to 4 and tri_in_ready=0; 5th triangle not accepted until a pop.
- Flip blocking: last triangle done, swap_req low 20 cycles, next frame's triangles pushed -> no rast_valid until swap_req; issue resumes 2 edges after flip.
- Spurious done: rast_done pulses in IDLE and ISSUE -> tri_count unchanged, state unchanged.
- Wrap-around: 10 triangles streamed at full rate through DEPTH=4 -> issued in push order with data bit-exact.
